// File: rtl/pipe_ks_adder_pkg.sv
// Shared types and constants for the pipelined Kogge-Stone adder.
// Stage fields are sized for the widest legal operand; narrower adders use the low bits.
package ks_adder_pkg;

  localparam int   KS_MAX_W = 64;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [KS_MAX_W-1:0] p;
    logic [KS_MAX_W-1:0] g;
    logic                sub;
  } stage_t;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/pipe_ks_adder_if.sv
// Operand/result valid-ready bundle for pipe_ks_adder; master drives operands, slave returns results.
interface pipe_ks_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;

  modport master (
    output in_valid, a_i, b_i, cin_i, sub_i, out_ready,
    input  in_ready, out_valid, sum_o, cout_o, ovf_o
  );

  modport slave (
    input  in_valid, a_i, b_i, cin_i, sub_i, out_ready,
    output in_ready, out_valid, sum_o, cout_o, ovf_o
  );
endinterface

// File: rtl/pipe_ks_adder_prefix_cell.sv
// Kogge-Stone black cell: merges group (gi,pi) with the lower group (gj,pj); purely combinational.
module ks_prefix_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic g,
  output logic p
);
  assign g = gi | (pi & gj);
  assign p = pi & pj;
endmodule

// File: rtl/pipe_ks_adder.sv
// Pipelined Kogge-Stone add/sub: LEVELS+2 cycle latency, one result per cycle.
// A stalled output (out_valid && !out_ready) freezes every stage and drops in_ready.
module pipe_ks_adder
  import ks_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LEVELS = ks_levels(WIDTH)
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  pipe_ks_adder_if.slave bus
);

  stage_t           st_q  [LEVELS+1];
  logic [WIDTH-1:0] pb_q  [LEVELS+1];
  logic             c0_q  [LEVELS+1];
  stage_t           s0_d;
  stage_t           lvl_d [LEVELS];
  logic [WIDTH-1:0] nx_g  [LEVELS];
  logic [WIDTH-1:0] nx_p  [LEVELS];

  logic             out_valid_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_d, ovf_d;
  logic             advance, accept, c0;
  logic [WIDTH-1:0] b_eff, p0, g0, carry;
  logic             unused_ok;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance && !wb_rst_i;
  assign accept       = bus.in_valid && bus.in_ready;

  // The carry-in is folded into bit 0 as the group below it, so the tree yields true carries.
  always_comb begin
    b_eff = (bus.sub_i == MODE_SUB) ? ~bus.b_i : bus.b_i;
    c0    = (bus.sub_i == MODE_SUB) ? 1'b1 : bus.cin_i;
    p0    = bus.a_i ^ b_eff;
    g0    = bus.a_i & b_eff;
    s0_d  = '0;
    if (accept) begin
      s0_d.valid          = 1'b1;
      s0_d.sub            = bus.sub_i;
      s0_d.p[WIDTH-1:0]   = {p0[WIDTH-1:1], 1'b0};
      s0_d.g[WIDTH-1:0]   = {g0[WIDTH-1:1], g0[0] | (p0[0] & c0)};
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << k;
    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
      if (i < SPAN) begin : g_pass
        assign nx_g[k][i] = st_q[k].g[i];
        assign nx_p[k][i] = st_q[k].p[i];
      end else begin : g_cell
        ks_prefix_cell u_cell (
          .gi (st_q[k].g[i]),
          .pi (st_q[k].p[i]),
          .gj (st_q[k].g[i-SPAN]),
          .pj (st_q[k].p[i-SPAN]),
          .g  (nx_g[k][i]),
          .p  (nx_p[k][i])
        );
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      lvl_d[k]              = st_q[k];
      lvl_d[k].p[WIDTH-1:0] = nx_p[k];
      lvl_d[k].g[WIDTH-1:0] = nx_g[k];
    end
  end

  always_comb begin
    carry  = st_q[LEVELS].g[WIDTH-1:0];
    sum_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    if (st_q[LEVELS].valid) begin
      sum_d  = pb_q[LEVELS] ^ {carry[WIDTH-2:0], c0_q[LEVELS]};
      cout_d = carry[WIDTH-1];
      ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k <= LEVELS; k++) begin
        st_q[k] <= '0;
        pb_q[k] <= '0;
        c0_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      st_q[0] <= s0_d;
      pb_q[0] <= accept ? p0 : '0;
      c0_q[0] <= accept && c0;
      for (int k = 0; k < LEVELS; k++) begin
        st_q[k+1] <= lvl_d[k];
        pb_q[k+1] <= pb_q[k];
        c0_q[k+1] <= c0_q[k];
      end
      out_valid_q <= st_q[LEVELS].valid;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  // High bits of the shared stage struct and the mode field are carried but never consumed.
  always_comb begin
    unused_ok = 1'b0;
    for (int k = 0; k <= LEVELS; k++) unused_ok = unused_ok ^ (^st_q[k]);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum_o     = sum_q;
  assign bus.cout_o    = cout_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_pipe_ks_adder.sv
// Scoreboard bench for pipe_ks_adder: random and directed beats against an arithmetic reference model.
module tb_pipe_ks_adder;
  import ks_adder_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 7;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           exact;
  } exp_t;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;
  exp_t sb_q[$];
  exp_t mon_h;
  bit   head_seen  = 1'b0;
  bit   rand_rdy   = 1'b0;
  bit   stall_arm  = 1'b0;
  int   stall_left = 0;

  pipe_ks_adder_if #(.WIDTH(W)) bus ();

  pipe_ks_adder #(.WIDTH(W)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic and signed-range overflow rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [W:0]  t;
    if (sub == MODE_ADD) begin
      t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum  = t[W-1:0];
      e.cout = t[W];
      e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    end else begin
      e.sum  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    e.cyc   = 0;
    e.exact = 1'b0;
    return e;
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit exact);
    exp_t e;
    e       = model(a, b, cin, sub);
    e.cyc   = cyc;
    e.exact = exact;
    sb_q.push_back(e);
  endtask

  task automatic step_setup();
    @(negedge wb_clk_i);
    if (stall_arm && bus.out_valid) begin
      stall_left = 5;
      stall_arm  = 1'b0;
    end
    if (stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
    end else begin
      bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic check_rdy();
    chk("in_ready", 64'(bus.in_ready), 64'((!bus.out_valid || bus.out_ready) && !wb_rst_i));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input bit exact);
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      step_setup();
      bus.in_valid = 1'b1;
      bus.a_i      = a;
      bus.b_i      = b;
      bus.cin_i    = cin;
      bus.sub_i    = sub;
      #1;
      check_rdy();
      if (bus.in_ready) begin
        push_exp(a, b, cin, sub, exact);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles, expected acceptance");
    end
  endtask

  task automatic idle();
    step_setup();
    bus.in_valid = 1'b0;
    bus.a_i      = $urandom;
    bus.b_i      = $urandom;
    bus.cin_i    = 1'($urandom & 1);
    bus.sub_i    = 1'($urandom & 1);
    #1;
    check_rdy();
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb_q.size() > 0; t++) idle();
    chk("drain_outstanding", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    bus.in_valid = 1'b0;
    wb_rst_i     = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum_o), 64'd0);
    chk("rst_flags", 64'({bus.cout_o, bus.ovf_o}), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    sb_q.delete();
    head_seen = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i      = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a_i       = 32'd5;
    bus.b_i       = 32'd6;
    bus.cin_i     = 1'b0;
    bus.sub_i     = MODE_ADD;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    push_exp(32'd5, 32'd6, 1'b0, MODE_ADD, 1'b1);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge wb_clk_i) begin
    #2;
    if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got sum 0x%0h with no beat outstanding, expected none", bus.sum_o);
      end else begin
        mon_h = sb_q[0];
        if (!head_seen) begin
          head_seen = 1'b1;
          if (mon_h.exact) chk("latency", 64'(cyc - mon_h.cyc), 64'(LAT));
        end
        chk("sum", 64'(bus.sum_o), 64'(mon_h.sum));
        chk("cout", 64'(bus.cout_o), 64'(mon_h.cout));
        chk("ovf", 64'(bus.ovf_o), 64'(mon_h.ovf));
        if (bus.out_ready) begin
          void'(sb_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end else begin
      chk("idle_outputs_zero", 64'({bus.sum_o, bus.cout_o, bus.ovf_o}), 64'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.cin_i     = 1'b0;
    bus.sub_i     = MODE_ADD;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_sum", 64'(bus.sum_o), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    send(32'h0000_0001, 32'h0000_0002, 1'b0, MODE_ADD, 1'b1);
    drain();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, MODE_ADD, 1'b1);
    drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, 1'b1);
    drain();

    stall_arm = 1'b1;
    for (int i = 0; i < 10; i++) send(rnd_op(), rnd_op(), 1'($urandom & 1), 1'($urandom & 1), 1'b0);
    drain();

    for (int i = 0; i < 4; i++) begin
      send(rnd_op(), rnd_op(), 1'($urandom & 1), 1'($urandom & 1), 1'b1);
      idle();
    end
    drain();

    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), 1'($urandom & 1), 1'($urandom & 1), 1'b0);
    do_reset();
    drain();
    repeat (20) idle();

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(rnd_op(), rnd_op(), 1'($urandom & 1), 1'($urandom & 1), 1'b0);
    end
    rand_rdy = 1'b0;
    drain();
    repeat (10) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ks_adder.md
PIPE_KS_ADDER -- requirements
Module: pipe_ks_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; legal values are powers of two, 4..64.
REQ-002 SHALL have parameter LEVELS, default $clog2(WIDTH), meaning the number of prefix levels; it is derived and never overridden.
REQ-003 SHALL have port wb_clk_i  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have ports a_i and b_i  input  WIDTH each  the operands.
REQ-008 SHALL have port cin_i  input  1  carry-in, used in add mode only.
REQ-009 SHALL have port sub_i  input  1  mode: 0 = a+b+cin, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum_o  output  WIDTH  the result.
REQ-013 SHALL have port cout_o  output  1  carry out of the MSB.
REQ-014 SHALL have port ovf_o  output  1  two's-complement overflow.

Function
REQ-015 SHALL compute:
- Stage 0 (registered): p = a^b', g = a&b', where b' = sub ? ~b : b.
- Effective carry-in c0 = sub ? 1 : cin.
REQ-016 SHALL perform one registered Kogge-Stone prefix level per stage, LEVELS stages in total:
- level k combines span 2^k.
- positions with index < 2^k pass through unchanged.
REQ-017 SHALL apply c0 as the group generate of position -1 so that it ripples through the prefix tree.
REQ-018 SHALL form the final stage (registered) as sum[i] = p[i] ^ carry[i-1]:
- cout = carry[WIDTH-1].
- ovf = carry[WIDTH-1] ^ carry[WIDTH-2].
REQ-019 SHALL have latency exactly LEVELS+2 cycles from an accepted input to out_valid with no stall; this is 7 cycles for WIDTH=32.
REQ-020 SHALL issue one result per cycle at sustained throughput.
REQ-021 SHALL carry a valid bit in every stage, together with the operand/mode data it needs.
REQ-022 SHALL define advance = !out_valid || out_ready:
- when advance = 0, every stage holds, including its valid bit and data.
REQ-023 SHALL drive in_ready = advance; a beat is accepted only when in_valid && in_ready.
REQ-024 SHALL ignore a_i, b_i, cin_i and sub_i when no beat is accepted.
REQ-025 SHALL hold sum_o, cout_o and ovf_o stable while out_valid && !out_ready.
REQ-026 SHALL drive the result outputs to 0 whenever out_valid = 0.
REQ-027 SHALL wrap around modulo 2^WIDTH; cout is reported and nothing saturates.
REQ-028 SHALL, when a bubble (in_valid = 0) is accepted, propagate it as valid = 0 and never produce an output beat for it.
REQ-029 SHALL preserve input order at the output with no loss or duplication.

Reset
REQ-030 SHALL, on wb_rst_i = 1, immediately clear all stage valid bits and data registers to 0 and force out_valid = 0, sum_o = 0, cout_o = 0 and ovf_o = 0.
REQ-031 SHALL hold in_ready = 0 while wb_rst_i = 1.
REQ-032 SHALL follow the rules below for reset asserted mid-operation:
- all in-flight beats are discarded;
- no result for them ever appears.
REQ-033 SHALL accept a beat on the first rising edge after wb_rst_i deasserts.

Structure
REQ-034 SHALL place the following in shared package ks_adder_pkg:
- the LEVELS derivation function;
- mode constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
- a packed stage struct {valid, p, g, sub}.
REQ-035 SHALL instantiate one sub-module, ks_prefix_cell, as a combinational black cell:
- inputs (gi, pi, gj, pj);
- outputs g = gi | (pi & gj), p = pi & pj;
- one instance per combining position per level.
REQ-036 SHALL express the sum as p XOR incoming carry, registered, with no separate sum module.

Verification (WIDTH=32)
REQ-037 SHALL cover add without carry:
- stimulus: a=0x0000_0001, b=0x0000_0002, cin=0, sub=0;
- response: sum=0x0000_0003, cout=0, ovf=0, exactly 7 cycles later.
REQ-038 SHALL cover the wrap-around boundary:
- stimulus: a=0xFFFF_FFFF, b=0x0000_0000, cin=1;
- response: sum=0, cout=1, ovf=0.
REQ-039 SHALL cover subtraction overflow:
- stimulus: sub=1, a=0x8000_0000, b=0x0000_0001;
- response: sum=0x7FFF_FFFF, cout=1, ovf=1.
REQ-040 SHALL cover back-pressure:
- stimulus: 10 back-to-back beats with out_ready=0 for 5 cycles after the first out_valid;
- response: in_ready=0 during the stall, the first result holds, and all 10 results arrive in order with none lost.
REQ-041 SHALL cover bubbles:
- stimulus: alternating in_valid=1/0 for 8 cycles;
- response: 4 results, each spaced 2 cycles apart.
REQ-042 SHALL cover reset mid-stream:
- stimulus: wb_rst_i asserted for 1 cycle when 3 beats are in flight;
- response: out_valid=0 immediately, no stale results appear afterwards, and a new beat 5+6 gives 11 after 7 cycles.
